// File: rtl/mux8x1_rr_arbiter.sv
// mux8x1_rr_arbiter
// Round-robin arbiter and select sequencer for the shared 8:1 single-bit mux.
// One requester owns the mux output at a time. A tenure is capped at MAX_HOLD
// cycles, but only while other requesters are waiting. The block also presents
// the selected data bit.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no grant outstanding; the next request is granted from ptr
// ST_BUSY  | sel owns the mux; released, rotated on expiry, or held

module mux8x1_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] d,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       y
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [0:0]       state, state_nxt;
   logic [2:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [7:0]       gnt_nxt;
   logic [2:0]       sel_nxt;
   logic             busy_nxt;

   logic [7:0]       owner_mask;
   logic [7:0]       others;
   logic             owner_req;
   logic             contention;
   logic [3:0]       pick_idle;
   logic [3:0]       pick_other;

   // Returns {found, index} for the first set bit of vec, searching
   // start, start+1, ... with wrap from 7 to 0. The loop runs from the
   // farthest offset to the nearest so the nearest set bit wins.
   function automatic logic [3:0] rr_pick(input logic [7:0] vec,
                                          input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (vec[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Contention view of the current owner and the candidate winners.
   always_comb begin
      owner_mask = 8'b1 << sel;
      others     = req & ~owner_mask;
      owner_req  = |(req & owner_mask);
      contention = |others;
      pick_idle  = rr_pick(req, ptr);
      pick_other = rr_pick(others, sel + 3'd1);
   end

   // Next-state and next-grant decision.
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      hold_cnt_nxt = hold_cnt;
      gnt_nxt      = gnt;
      sel_nxt      = sel;
      busy_nxt     = busy;

      case (state)
         ST_IDLE: begin
            if (pick_idle[3]) begin
               state_nxt    = ST_BUSY;
               sel_nxt      = pick_idle[2:0];
               gnt_nxt      = 8'b1 << pick_idle[2:0];
               busy_nxt     = 1'b1;
               hold_cnt_nxt = '0;
               ptr_nxt      = pick_idle[2:0] + 3'd1;
            end
         end

         ST_BUSY: begin
            if (!owner_req) begin
               // Release also takes priority over a coincident expiry.
               if (pick_other[3]) begin
                  sel_nxt      = pick_other[2:0];
                  gnt_nxt      = 8'b1 << pick_other[2:0];
                  hold_cnt_nxt = '0;
                  ptr_nxt      = pick_other[2:0] + 3'd1;
               end else begin
                  // sel deliberately keeps its last value while idle.
                  state_nxt    = ST_IDLE;
                  gnt_nxt      = 8'h00;
                  busy_nxt     = 1'b0;
                  hold_cnt_nxt = '0;
               end
            end else if (contention && (hold_cnt == HOLD_LAST)) begin
               sel_nxt      = pick_other[2:0];
               gnt_nxt      = 8'b1 << pick_other[2:0];
               hold_cnt_nxt = '0;
               ptr_nxt      = pick_other[2:0] + 3'd1;
            end else if (contention) begin
               // Below HOLD_LAST here, so the counter cannot wrap.
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end else begin
               // A lone requester holds indefinitely.
               hold_cnt_nxt = '0;
            end
         end

         default: begin
            state_nxt    = ST_IDLE;
            gnt_nxt      = 8'h00;
            busy_nxt     = 1'b0;
            hold_cnt_nxt = '0;
         end
      endcase
   end

   // State, grant and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= 3'd0;
         hold_cnt <= '0;
         gnt      <= 8'h00;
         sel      <= 3'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_cnt_nxt;
         gnt      <= gnt_nxt;
         sel      <= sel_nxt;
         busy     <= busy_nxt;
      end
   end

   // Muxed data bit; forced low while nothing is granted.
   always_comb begin
      y = busy ? d[sel] : 1'b0;
   end

endmodule
